// File: rtl/id_ex_stage_pkg.sv
// Shared decode constants and the control bundle type used by the ID/EX stage.
package id_ex_stage_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } aluop_e;

  // ALUSrc selects REG/IMM for operand B; MemtoReg selects MEM for writeback
  localparam logic REG = 1'b0;
  localparam logic IMM = 1'b1;
  localparam logic MEM = 1'b1;

  typedef struct packed {
    logic   RegWrite;
    logic   MemtoReg;
    logic   MemRead;
    logic   MemWrite;
    logic   ALUSrc;
    aluop_e ALUOp;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_NOP = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_ADD};

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side inputs and EX-side outputs of the ID/EX stage; slave is the stage itself.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i;
  logic [1:0]        ALUOp_i;
  logic [DATA_W-1:0] RS1data_i, RS2data_i, Imm_i;
  logic [9:0]        Funct_i;
  logic [REG_AW-1:0] RS1addr_i, RS2addr_i, RDaddr_i;

  logic              RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o;
  logic [1:0]        ALUOp_o;
  logic [DATA_W-1:0] RS1data_o, RS2data_o, Imm_o;
  logic [9:0]        Funct_o;
  logic [REG_AW-1:0] RS1addr_o, RS2addr_o, RDaddr_o;
  logic              Stall_o, PCWrite_o, IFIDWrite_o;

  modport slave (
    input  RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, ALUOp_i,
           RS1data_i, RS2data_i, Imm_i, Funct_i, RS1addr_i, RS2addr_i, RDaddr_i,
    output RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, ALUOp_o,
           RS1data_o, RS2data_o, Imm_o, Funct_o, RS1addr_o, RS2addr_o, RDaddr_o,
           Stall_o, PCWrite_o, IFIDWrite_o
  );

  modport master (
    output RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, ALUOp_i,
           RS1data_i, RS2data_i, Imm_i, Funct_i, RS1addr_i, RS2addr_i, RDaddr_i,
    input  RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, ALUOp_o,
           RS1data_o, RS2data_o, Imm_o, Funct_o, RS1addr_o, RS2addr_o, RDaddr_o,
           Stall_o, PCWrite_o, IFIDWrite_o
  );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard compare: EX load whose destination is read by the ID instruction.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  output logic              stall_o
);
  always_comb begin
    stall_o = ex_memread_i && (ex_rd_i != '0) &&
              ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
  end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and global freeze.
// Define ID_EX_PERF_EN to add BubbleCnt_o / FreezeCnt_o event counters.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        Freeze_i,
`ifdef ID_EX_PERF_EN
  output logic [31:0] BubbleCnt_o,
  output logic [31:0] FreezeCnt_o,
`endif
  id_ex_stage_if.slave bus
);
  ctrl_bundle_t      ctrl_q, ctrl_d, id_ctrl;
  logic [DATA_W-1:0] rs1data_q, rs1data_d, rs2data_q, rs2data_d, imm_q, imm_d;
  logic [9:0]        funct_q, funct_d;
  logic [REG_AW-1:0] rs1addr_q, rs1addr_d, rs2addr_q, rs2addr_d, rdaddr_q, rdaddr_d;
  logic              stall;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .ex_memread_i (ctrl_q.MemRead),
    .ex_rd_i      (rdaddr_q),
    .id_rs1_i     (bus.RS1addr_i),
    .id_rs2_i     (bus.RS2addr_i),
    .stall_o      (stall)
  );

  always_comb begin
    id_ctrl = '{bus.RegWrite_i, bus.MemtoReg_i, bus.MemRead_i, bus.MemWrite_i,
                bus.ALUSrc_i, aluop_e'(bus.ALUOp_i)};
    ctrl_d    = ctrl_q;
    rs1data_d = rs1data_q;
    rs2data_d = rs2data_q;
    imm_d     = imm_q;
    funct_d   = funct_q;
    rs1addr_d = rs1addr_q;
    rs2addr_d = rs2addr_q;
    rdaddr_d  = rdaddr_q;
    // Freeze wins over the bubble, so a pending hazard keeps Stall_o high until release
    if (!Freeze_i) begin
      ctrl_d    = stall ? CTRL_NOP : id_ctrl;
      rs1data_d = bus.RS1data_i;
      rs2data_d = bus.RS2data_i;
      imm_d     = bus.Imm_i;
      funct_d   = bus.Funct_i;
      rs1addr_d = bus.RS1addr_i;
      rs2addr_d = bus.RS2addr_i;
      rdaddr_d  = bus.RDaddr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ctrl_q    <= CTRL_NOP;
      rs1data_q <= '0;
      rs2data_q <= '0;
      imm_q     <= '0;
      funct_q   <= '0;
      rs1addr_q <= '0;
      rs2addr_q <= '0;
      rdaddr_q  <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      rs1data_q <= rs1data_d;
      rs2data_q <= rs2data_d;
      imm_q     <= imm_d;
      funct_q   <= funct_d;
      rs1addr_q <= rs1addr_d;
      rs2addr_q <= rs2addr_d;
      rdaddr_q  <= rdaddr_d;
    end
  end

  always_comb begin
    bus.RegWrite_o  = ctrl_q.RegWrite;
    bus.MemtoReg_o  = ctrl_q.MemtoReg;
    bus.MemRead_o   = ctrl_q.MemRead;
    bus.MemWrite_o  = ctrl_q.MemWrite;
    bus.ALUSrc_o    = ctrl_q.ALUSrc;
    bus.ALUOp_o     = ctrl_q.ALUOp;
    bus.RS1data_o   = rs1data_q;
    bus.RS2data_o   = rs2data_q;
    bus.Imm_o       = imm_q;
    bus.Funct_o     = funct_q;
    bus.RS1addr_o   = rs1addr_q;
    bus.RS2addr_o   = rs2addr_q;
    bus.RDaddr_o    = rdaddr_q;
    bus.Stall_o     = stall;
    bus.PCWrite_o   = !stall && !Freeze_i;
    bus.IFIDWrite_o = !stall && !Freeze_i;
  end

`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d, freeze_cnt_q, freeze_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q + {31'd0, (stall && !Freeze_i)};
    freeze_cnt_d = freeze_cnt_q + {31'd0, Freeze_i};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bubble_cnt_q <= '0;
      freeze_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign BubbleCnt_o = bubble_cnt_q;
  assign FreezeCnt_o = freeze_cnt_q;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (perf counters checked when ID_EX_PERF_EN is defined).
module tb_id_ex_stage;
  typedef struct packed {
    logic rw, mtr, mr, mw, as;
    logic [1:0]  aluop;
    logic [31:0] d1, d2, imm;
    logic [9:0]  funct;
    logic [4:0]  a1, a2, rd;
  } id_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic freeze = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_cnt, freeze_cnt;
`endif

  id_ex_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .Freeze_i (freeze),
`ifdef ID_EX_PERF_EN
    .BubbleCnt_o (bubble_cnt),
    .FreezeCnt_o (freeze_cnt),
`endif
    .bus      (bus)
  );

  always #5 clk = ~clk;

  function automatic id_t mk(input logic rw, mtr, mr, mw, as, input logic [1:0] aluop,
                             input logic [31:0] d1, d2, imm, input logic [9:0] funct,
                             input logic [4:0] a1, a2, rd);
    id_t v;
    v = '{rw, mtr, mr, mw, as, aluop, d1, d2, imm, funct, a1, a2, rd};
    return v;
  endfunction

  function automatic id_t bubble(input id_t v);
    id_t b;
    b = v;
    {b.rw, b.mtr, b.mr, b.mw, b.as, b.aluop} = '0;
    return b;
  endfunction

  function automatic id_t ex_obs();
    id_t o;
    o = '{bus.RegWrite_o, bus.MemtoReg_o, bus.MemRead_o, bus.MemWrite_o, bus.ALUSrc_o,
          bus.ALUOp_o, bus.RS1data_o, bus.RS2data_o, bus.Imm_o, bus.Funct_o,
          bus.RS1addr_o, bus.RS2addr_o, bus.RDaddr_o};
    return o;
  endfunction

  task automatic drive(input id_t v);
    bus.RegWrite_i = v.rw;  bus.MemtoReg_i = v.mtr; bus.MemRead_i = v.mr;
    bus.MemWrite_i = v.mw;  bus.ALUSrc_i   = v.as;  bus.ALUOp_i   = v.aluop;
    bus.RS1data_i  = v.d1;  bus.RS2data_i  = v.d2;  bus.Imm_i     = v.imm;
    bus.Funct_i    = v.funct;
    bus.RS1addr_i  = v.a1;  bus.RS2addr_i  = v.a2;  bus.RDaddr_i  = v.rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    id_t r, a;
    r = {$urandom, $urandom, $urandom, $urandom};
    rst_n = 1'b0;
    drive(r);
    #2;
    vectors++;
    if (ex_obs() !== id_t'('0)) begin
      miscompares++; $display("FAIL reset_ex got %h exp %h", ex_obs(), id_t'('0));
    end
    vectors++;
    if ({bus.Stall_o, bus.PCWrite_o, bus.IFIDWrite_o} !== 3'b011) begin
      miscompares++;
      $display("FAIL reset_stall got %b exp 011", {bus.Stall_o, bus.PCWrite_o, bus.IFIDWrite_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    a = mk(1, 0, 0, 1, 1, 2'b11, 32'h1111_2222, 32'h3333_4444, 32'hFFFF_FF80, 10'h2A5, 5'd3, 5'd4, 5'd9);
    drive(a);
    tick();
    vectors++;
    if (ex_obs() !== a) begin
      miscompares++; $display("FAIL reset_first_latch got %h exp %h", ex_obs(), a);
    end
  endtask

  task automatic test_load_use();
    id_t lw, add, lw7, sub;
    lw  = mk(1, 1, 1, 0, 1, 2'b00, 32'h0000_1000, 32'h0, 32'h0000_0010, 10'h002, 5'd2, 5'd0, 5'd5);
    add = mk(1, 0, 0, 0, 0, 2'b10, 32'hAAAA_0001, 32'hBBBB_0002, 32'h0, 10'h000, 5'd5, 5'd1, 5'd6);
    drive(lw);
    #1;
    vectors++;
    if (bus.Stall_o !== 1'b0) begin
      miscompares++; $display("FAIL lu_pre_stall got %b exp 0", bus.Stall_o);
    end
    tick();
    drive(add);
    #1;
    vectors++;
    if ({bus.Stall_o, bus.PCWrite_o, bus.IFIDWrite_o} !== 3'b100) begin
      miscompares++;
      $display("FAIL lu_rs1_stall got %b exp 100", {bus.Stall_o, bus.PCWrite_o, bus.IFIDWrite_o});
    end
    tick();
    vectors++;
    if (ex_obs() !== bubble(add)) begin
      miscompares++; $display("FAIL lu_bubble got %h exp %h", ex_obs(), bubble(add));
    end
    vectors++;
    if ({bus.Stall_o, bus.PCWrite_o, bus.IFIDWrite_o} !== 3'b011) begin
      miscompares++;
      $display("FAIL lu_after_bubble got %b exp 011", {bus.Stall_o, bus.PCWrite_o, bus.IFIDWrite_o});
    end
    tick();
    vectors++;
    if (ex_obs() !== add) begin
      miscompares++; $display("FAIL lu_add_ex got %h exp %h", ex_obs(), add);
    end
    // rs2 side of the compare
    lw7 = mk(1, 1, 1, 0, 1, 2'b00, 32'h0000_2000, 32'h0, 32'h0000_0004, 10'h002, 5'd8, 5'd0, 5'd7);
    sub = mk(1, 0, 0, 0, 0, 2'b10, 32'h5, 32'h3, 32'h0, 10'h100, 5'd12, 5'd7, 5'd13);
    drive(lw7);
    tick();
    drive(sub);
    #1;
    vectors++;
    if (bus.Stall_o !== 1'b1) begin
      miscompares++; $display("FAIL lu_rs2_stall got %b exp 1", bus.Stall_o);
    end
    tick();
    vectors++;
    if (ex_obs() !== bubble(sub)) begin
      miscompares++; $display("FAIL lu_rs2_bubble got %h exp %h", ex_obs(), bubble(sub));
    end
    tick();
  endtask

  task automatic test_x0();
    id_t ld0, use0;
    ld0  = mk(1, 1, 1, 0, 1, 2'b00, 32'h40, 32'h0, 32'h8, 10'h002, 5'd10, 5'd0, 5'd0);
    use0 = mk(1, 0, 0, 0, 0, 2'b10, 32'h0, 32'h77, 32'h0, 10'h000, 5'd0, 5'd0, 5'd11);
    drive(ld0);
    tick();
    drive(use0);
    #1;
    vectors++;
    if ({bus.Stall_o, bus.PCWrite_o} !== 2'b01) begin
      miscompares++; $display("FAIL x0_stall got %b exp 01", {bus.Stall_o, bus.PCWrite_o});
    end
    tick();
    vectors++;
    if (ex_obs() !== use0) begin
      miscompares++; $display("FAIL x0_ex got %h exp %h", ex_obs(), use0);
    end
  endtask

  task automatic test_freeze();
    id_t held, lw9, use9;
    held = ex_obs();
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(mk(1, 0, 0, 0, 1, 2'b11, $urandom, $urandom, $urandom, 10'(i + 5),
               5'(i + 20), 5'(i + 24), 5'(i + 28)));
      #1;
      vectors++;
      if ({bus.PCWrite_o, bus.IFIDWrite_o} !== 2'b00) begin
        miscompares++; $display("FAIL frz_pcwrite got %b exp 00", {bus.PCWrite_o, bus.IFIDWrite_o});
      end
      tick();
      vectors++;
      if (ex_obs() !== held) begin
        miscompares++; $display("FAIL frz_hold got %h exp %h", ex_obs(), held);
      end
    end
    freeze = 1'b0;
    lw9  = mk(1, 1, 1, 0, 1, 2'b00, 32'h900, 32'h0, 32'h0, 10'h002, 5'd1, 5'd0, 5'd9);
    use9 = mk(1, 0, 0, 1, 1, 2'b00, 32'h99, 32'h98, 32'hC, 10'h002, 5'd9, 5'd2, 5'd0);
    drive(lw9);
    tick();
    drive(use9);
    freeze = 1'b1;
    tick();
    vectors++;
    if (ex_obs() !== lw9 || bus.Stall_o !== 1'b1) begin
      miscompares++;
      $display("FAIL frz_pending got %h/%b exp %h/1", ex_obs(), bus.Stall_o, lw9);
    end
    freeze = 1'b0;
    #1;
    vectors++;
    if ({bus.Stall_o, bus.PCWrite_o} !== 2'b10) begin
      miscompares++; $display("FAIL frz_release_stall got %b exp 10", {bus.Stall_o, bus.PCWrite_o});
    end
    tick();
    vectors++;
    if (ex_obs() !== bubble(use9)) begin
      miscompares++; $display("FAIL frz_bubble got %h exp %h", ex_obs(), bubble(use9));
    end
  endtask

  task automatic test_async_reset();
    id_t lw3, use3;
    lw3  = mk(1, 1, 1, 0, 1, 2'b00, 32'h300, 32'h0, 32'h0, 10'h002, 5'd1, 5'd0, 5'd3);
    use3 = mk(1, 0, 0, 0, 0, 2'b10, 32'h1, 32'h2, 32'h0, 10'h000, 5'd4, 5'd3, 5'd15);
    drive(lw3);
    tick();
    drive(use3);
    #1;
    vectors++;
    if (bus.Stall_o !== 1'b1) begin
      miscompares++; $display("FAIL ar_pre_stall got %b exp 1", bus.Stall_o);
    end
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (ex_obs() !== id_t'('0)) begin
      miscompares++; $display("FAIL ar_ex got %h exp %h", ex_obs(), id_t'('0));
    end
    vectors++;
    if ({bus.Stall_o, bus.PCWrite_o, bus.IFIDWrite_o} !== 3'b011) begin
      miscompares++;
      $display("FAIL ar_stall got %b exp 011", {bus.Stall_o, bus.PCWrite_o, bus.IFIDWrite_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef ID_EX_PERF_EN
  task automatic test_perf();
    id_t nop;
    nop = '0;
    drive(nop);
    #1;
    vectors++;
    if ({bubble_cnt, freeze_cnt} !== 64'd0) begin
      miscompares++; $display("FAIL perf_reset got %0d/%0d exp 0/0", bubble_cnt, freeze_cnt);
    end
    drive(mk(1, 1, 1, 0, 1, 2'b00, 32'h0, 32'h0, 32'h0, 10'h0, 5'd1, 5'd0, 5'd5));
    tick();
    drive(mk(1, 0, 0, 0, 0, 2'b10, 32'h0, 32'h0, 32'h0, 10'h0, 5'd5, 5'd1, 5'd6));
    tick();
    tick();
    drive(mk(1, 1, 1, 0, 1, 2'b00, 32'h0, 32'h0, 32'h0, 10'h0, 5'd1, 5'd0, 5'd6));
    tick();
    drive(mk(1, 0, 0, 0, 0, 2'b10, 32'h0, 32'h0, 32'h0, 10'h0, 5'd2, 5'd6, 5'd7));
    tick();
    drive(nop);
    freeze = 1'b1;
    repeat (4) tick();
    freeze = 1'b0;
    vectors++;
    if (bubble_cnt !== 32'd2) begin
      miscompares++; $display("FAIL perf_bubble got %0d exp 2", bubble_cnt);
    end
    vectors++;
    if (freeze_cnt !== 32'd4) begin
      miscompares++; $display("FAIL perf_freeze got %0d exp 4", freeze_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_x0();
    test_freeze();
    test_async_reset();
`ifdef ID_EX_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
